div_radix2: RTL and testbench

- Multi-cycle 32-bit signed/unsigned integer divider for the EX stage of the 5-stage MIPS pipeline.
- It is the producer side of the divide stall handshake: the hazard unit stalls EX with `isdivE & ~divreadyE`, and this block raises `ready` when the result is valid.
- Uses radix-2 restoring division, one quotient bit per cycle.
- Result is packed `{hi = remainder, lo = quotient}`. The pipeline carries it to ME/WB, where it is forwarded as the multdivresult path.

---
 rtl/div_radix2_pkg.sv | 22 ++
 rtl/div_radix2_if.sv | 31 +++
 rtl/div_radix2.sv | 129 ++++++++++++
 tb/tb_div_radix2.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_radix2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_radix2_pkg
// Description : Shared constants for the radix-2 restoring divider: FSM state
//               encodings, iteration count and counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package div_radix2_pkg;

  // Operand width / number of quotient bits produced, one per BUSY cycle
  localparam int DIV_ITER  = 32;
  // Iteration counter width; must be able to hold DIV_ITER
  localparam int DIV_CNT_W = 6;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_BUSY = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

endpackage : div_radix2_pkg
`default_nettype wire

// File: rtl/div_radix2_if.sv
`default_nettype none
// ============================================================================
// Module      : div_radix2_if
// Description : Request/result bundle between the EX stage (master) and the
//               multi-cycle divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface div_radix2_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 annul;
  logic                 stall_i;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;

  modport master (
    output start, signed_div, a, b, annul, stall_i,
    input  ready, result, busy
  );

  modport slave (
    input  start, signed_div, a, b, annul, stall_i,
    output ready, result, busy
  );
endinterface : div_radix2_if
`default_nettype wire

// File: rtl/div_radix2.sv
`default_nettype none
// ============================================================================
// Module      : div_radix2
// Description : Multi-cycle signed/unsigned radix-2 restoring divider for the
//               EX stage. One quotient bit per cycle; result is packed as
//               {remainder, quotient} and valid while ready is high.
// Revision    : 1.0 - initial release
// ============================================================================
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = DIV_ITER,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  div_radix2_if.slave  bus
);

  div_state_t          state_q, state_d;
  logic [WIDTH-1:0]    dvd_q, dvd_d;       // dividend shifts out the top, quotient shifts in the bottom
  logic [WIDTH-1:0]    dsr_q, dsr_d;       // divisor magnitude
  logic [WIDTH-1:0]    rem_q, rem_d;       // partial remainder
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sgn_quo_q, sgn_quo_d;
  logic                sgn_rem_q, sgn_rem_d;
  logic                held_q, held_d;     // completion was held by a downstream stall
  logic [2*WIDTH-1:0]  result_q, result_d;

  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic                launch, last_iter;
  logic [WIDTH:0]      shifted, trial;
  logic                trial_ok;
  logic [WIDTH-1:0]    quo_next, rem_next, quo_fix, rem_fix;

  // Operand magnitudes, launch qualification and one restoring step.
  // The shifted remainder keeps its top bit so the trial subtract is exact.
  always_comb begin
    a_neg     = bus.signed_div & bus.a[WIDTH-1];
    b_neg     = bus.signed_div & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
    // After a stall-held completion the old instruction's start is still
    // visible for one IDLE cycle, so that cycle does not launch.
    launch    = (state_q == DIV_IDLE) & bus.start & ~bus.annul & ~held_q;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    shifted   = {rem_q, dvd_q[WIDTH-1]};
    trial     = shifted - {1'b0, dsr_q};
    trial_ok  = ~trial[WIDTH];
    rem_next  = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next  = {dvd_q[WIDTH-2:0], trial_ok};
    quo_fix   = sgn_quo_q ? -quo_next : quo_next;
    rem_fix   = sgn_rem_q ? -rem_next : rem_next;
  end

  // Datapath next-state: latch operands on launch, iterate while BUSY.
  always_comb begin
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    result_d  = result_q;
    held_d    = (state_q == DIV_DONE) & ~bus.annul & (held_q | bus.stall_i);
    if (launch) begin
      dvd_d     = a_mag;
      dsr_d     = b_mag;
      rem_d     = '0;
      cnt_d     = '0;
      sgn_quo_d = a_neg ^ b_neg;
      sgn_rem_d = a_neg;
    end else if ((state_q == DIV_BUSY) && !bus.annul) begin
      dvd_d = quo_next;
      rem_d = rem_next;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) begin
        result_d = {rem_fix, quo_fix};
      end
    end
  end

  // FSM next-state: annul aborts any operation, stall holds a finished result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (launch)                      state_d = DIV_BUSY;
      DIV_BUSY: if (bus.annul)                   state_d = DIV_IDLE;
                else if (last_iter)              state_d = DIV_DONE;
      DIV_DONE: if (bus.annul || !bus.stall_i)   state_d = DIV_IDLE;
      default:                                   state_d = DIV_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      held_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      held_q    <= held_d;
      result_q  <= result_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    bus.ready  = (state_q == DIV_DONE);
    bus.busy   = (state_q == DIV_BUSY);
    bus.result = result_q;
  end

endmodule : div_radix2
`default_nettype wire

// File: tb/tb_div_radix2.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_radix2
// Description : Directed self-checking bench for div_radix2: a table of
//               divide vectors plus stall, back-to-back, annul and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_radix2;

  localparam int W  = 32;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_radix2_if #(.WIDTH(W)) bus();

  div_radix2 #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;   // {remainder, quotient}
  } vec_t;

  vec_t vecs [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a divide with start held until ready or the cycle budget expires.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, output int lat);
    bus.a          = a;
    bus.b          = b;
    bus.signed_div = sgn;
    bus.start      = 1'b1;
    lat            = 0;
    while (bus.ready !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          n;
    logic        seen;
    logic [63:0] held_res;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          sgn: 1'b0, exp: {32'h00000002, 32'h0000000E}};
    vecs[1] = '{a: 32'hFFFFFFF9,   b: 32'd2,          sgn: 1'b1, exp: {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2] = '{a: 32'd7,          b: 32'hFFFFFFFE,   sgn: 1'b1, exp: {32'h00000001, 32'hFFFFFFFD}};
    vecs[3] = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   sgn: 1'b1, exp: {32'h00000000, 32'h80000000}};
    vecs[4] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   sgn: 1'b0, exp: {32'h00000000, 32'h00000001}};
    vecs[5] = '{a: 32'd5,          b: 32'd0,          sgn: 1'b0, exp: {32'h00000005, 32'hFFFFFFFF}};
    vecs[6] = '{a: 32'hFFFFFFFB,   b: 32'd0,          sgn: 1'b1, exp: {32'hFFFFFFFB, 32'h00000001}};
    vecs[7] = '{a: 32'hFFFFFFF9,   b: 32'd2,          sgn: 1'b0, exp: {32'h00000001, 32'h7FFFFFFC}};
    vecs[8] = '{a: 32'hFFFFFF9C,   b: 32'd7,          sgn: 1'b1, exp: {32'hFFFFFFFE, 32'hFFFFFFF2}};
    vecs[9] = '{a: 32'h12345678,   b: 32'h00000100,   sgn: 1'b0, exp: {32'h00000078, 32'h00123456}};

    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.annul      = 1'b0;
    bus.stall_i    = 1'b0;
    rst            = 1'b1;
    step();
    step();
    check("reset ready",  64'(bus.ready), 64'd0);
    check("reset busy",   64'(bus.busy),  64'd0);
    check("reset result", bus.result,     64'd0);
    rst = 1'b0;
    step();

    // annul in IDLE suppresses launch
    bus.a = 32'd10; bus.b = 32'd3; bus.start = 1'b1; bus.annul = 1'b1;
    step();
    check("idle annul busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0; bus.annul = 1'b0;
    step();

    // table-driven vectors, start dropped once ready is seen
    for (int i = 0; i < NV; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d result", i), bus.result, vecs[i].exp);
      bus.start = 1'b0;
      step();
      check($sformatf("vec%0d ready width", i), 64'(bus.ready), 64'd0);
    end

    // stall_i held 3 cycles in DONE with start still high
    run_div(32'd9, 32'd4, 1'b0, lat);
    check("stall latency", 64'(lat), 64'd33);
    check("stall result", bus.result, {32'd1, 32'd2});
    held_res    = bus.result;
    bus.stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall hold%0d ready", k), 64'(bus.ready), 64'd1);
      check($sformatf("stall hold%0d result", k), bus.result, held_res);
    end
    bus.stall_i = 1'b0;
    step();
    check("stall release ready", 64'(bus.ready), 64'd0);
    check("stall release busy",  64'(bus.busy),  64'd0);
    step();
    check("stall no relaunch", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    step();

    // back-to-back: 20/3 then 20/6 with start continuously high
    run_div(32'd20, 32'd3, 1'b0, lat);
    check("b2b first latency", 64'(lat), 64'd33);
    check("b2b first result", bus.result, {32'd2, 32'd6});
    bus.a = 32'd20; bus.b = 32'd6;
    step();
    check("b2b gap ready", 64'(bus.ready), 64'd0);
    n = 1;
    while (bus.ready !== 1'b1 && n < 45) begin
      step();
      n++;
    end
    check("b2b pulse spacing", 64'(n), 64'd34);
    check("b2b second result", bus.result, {32'd2, 32'd3});
    bus.start = 1'b0;
    step();

    // annul at BUSY iteration 10
    bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check("annul pre busy", 64'(bus.busy), 64'd1);
    bus.annul = 1'b1;
    step();
    check("annul busy",  64'(bus.busy),  64'd0);
    check("annul ready", 64'(bus.ready), 64'd0);
    bus.annul = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.ready === 1'b1) seen = 1'b1;
    end
    check("annul no ready", 64'(seen), 64'd0);

    // reset in the middle of BUSY
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    check("midrst ready",  64'(bus.ready), 64'd0);
    check("midrst busy",   64'(bus.busy),  64'd0);
    check("midrst result", bus.result,     64'd0);
    rst = 1'b0;
    step();

    run_div(32'd9, 32'd3, 1'b0, lat);
    check("post rst latency", 64'(lat), 64'd33);
    check("post rst result", bus.result, {32'd0, 32'd3});
    bus.start = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_div_radix2
`default_nettype wire
